decay_sweep_controller: RTL and testbench
=========================================

Name: decay_sweep_controller

Overview:
- Timestep-level sequencer for the membrane-potential decay datapath.
- On each timestep start pulse, sweeps neuron addresses 0..N-1 in order. For each neuron it reads potential and decay rate from the neuron state memory, hands them to the float decay unit (req/done handshake) and writes the result back.
- Shares the state memory with the potential adder. The adder always has priority.
- Sits between the timestep generator, the neuron state memory and the decay unit.

Parameters:
- ADDR_W, 12, neuron address width
- DATA_W, 32, potential width (IEEE-754 single)
- RATE_W, 4, decay-rate code width

Ports:
- CLK  in  1  clock, rising edge
- RESET  in  1  asynchronous, active-high reset
- timestep_start  in  1  one-cycle pulse that begins a sweep
- neuron_count  in  ADDR_W  number of neurons to sweep; sampled on an accepted start
- adder_busy  in  1  potential adder owns memory this cycle
- mem_rd_en  out  1  memory read strobe
- mem_wr_en  out  1  memory write strobe
- mem_addr  out  ADDR_W  read/write address
- mem_wr_data  out  DATA_W  write-back potential
- mem_rd_data  in  DATA_W  potential; valid the cycle after mem_rd_en
- mem_rd_rate  in  RATE_W  decay rate; valid the cycle after mem_rd_en
- decay_start  out  1  one-cycle request to the decay unit
- decay_potential  out  DATA_W  operand to the decay unit
- decay_rate  out  RATE_W  rate to the decay unit
- decay_done  in  1  decay result valid
- decay_result  in  DATA_W  decayed potential
- busy  out  1  sweep in progress
- sweep_done  out  1  one-cycle pulse at end of sweep
- overrun  out  1  sticky flag: start pulse arrived while busy

Behaviour:
- Reset (async, RESET=1):
  - State goes to IDLE.
  - All outputs 0; mem_addr=0; internal registers 0; overrun cleared.
  - Reset mid-sweep aborts immediately. No partial write is issued after reset deasserts.
- IDLE:
  - busy=0.
  - On timestep_start: latch cnt=neuron_count and set addr=0.
  - If cnt≠0, go to RD; otherwise go to DONE.
- RD:
  - busy=1.
  - mem_rd_en = !adder_busy (combinational); go to CAP only when the read issues, else hold.
- CAP: register mem_rd_data into pot_q and mem_rd_rate into rate_q; go to ISSUE.
- ISSUE: decay_start=1 for exactly one cycle; decay_potential=pot_q, decay_rate=rate_q; go to WAITD.
- WAITD:
  - decay_done is sampled only in this state; a done pulse in any other state is ignored.
  - On done, latch decay_result into res_q and go to WR. No timeout.
- WR:
  - mem_wr_en = !adder_busy; mem_wr_data=res_q; mem_addr=addr.
  - When the write issues: if addr==cnt-1 go to DONE, else addr+1 and go to RD.
  - When the write is blocked, hold WR.
- DONE: sweep_done=1 for one cycle; busy=0; go to IDLE.
- Output hold: decay_potential/decay_rate hold their values from ISSUE until the next CAP.
- mem_addr always reflects addr while busy.
- Latency, no stalls, decay_done one cycle after decay_start:
  - 5 cycles per neuron (RD, CAP, ISSUE, WAITD, WR).
  - Sweep of N neurons: 5N cycles, then DONE.
- Overrun: timestep_start in any non-IDLE state is ignored and sets overrun=1. overrun stays set until RESET.
- Simultaneous events:
  - adder_busy and a pending strobe: the strobe is suppressed that cycle; no state change.
  - timestep_start in the DONE cycle counts as overrun.
- Wrap-around:
  - neuron_count=2^ADDR_W-1 is legal. addr never exceeds cnt-1.
  - neuron_count=0: sweep_done pulses the cycle after start, with no memory traffic.
- Changes to neuron_count during a sweep have no effect.

Optional Feature:
- Macro DECAY_ZERO_SKIP_EN.
- Defined: in CAP, if mem_rd_data[30:23]==0 (zero/denormal), skip ISSUE, WAITD and WR and go directly to the next address (or DONE). That neuron costs 2 cycles and generates no decay_start and no mem_wr_en.
- Undefined: every neuron is processed normally, including zeros.

Test Plan:
- Reset then idle: all outputs 0, busy=0, overrun=0; no strobes for 20 cycles.
- Sweep of 4 neurons, no stalls:
  - Stimulus: neuron_count=4, memory holds 0x41000000 (8.0), rate 4'b0010 at all addresses; model returns 0x40800000 one cycle after decay_start.
  - Required: four writes of 0x40800000 to addresses 0..3; sweep_done exactly 21 cycles after the start pulse; busy high throughout the sweep.
- Adder contention: adder_busy held high 3 cycles during RD of address 1 and 2 cycles during WR of address 2 -> sweep_done delayed by exactly 5 cycles; no strobe while adder_busy=1; data unchanged.
- Slow decay unit: decay_done delayed 7 cycles, plus a spurious decay_done in CAP -> spurious done ignored; write data correct; only one decay_start per neuron.
- Overrun and zero count:
  - timestep_start mid-sweep -> overrun=1, sweep unaffected.
  - neuron_count=0 -> sweep_done one cycle after start, no mem strobes.
- Reset mid-WAITD, then with DECAY_ZERO_SKIP_EN:
  - Reset in WAITD -> no write occurs; state IDLE.
  - With DECAY_ZERO_SKIP_EN and address 1 holding 0x00000000 -> no decay_start and no write for address 1; 4-neuron sweep finishes in 18 cycles.

Source files
------------

// File: rtl/decay_sweep_controller.sv
// rtl/decay_sweep_controller.sv - timestep sweep sequencer for the membrane-potential decay datapath
//
// On each accepted timestep_start, walks neuron addresses 0..cnt-1. For each neuron it:
//   1. reads potential and rate from the shared state memory,
//   2. hands them to the float decay unit,
//   3. writes the decayed potential back.
// The potential adder has priority on the memory (adder_busy).
//
// Optional feature: define DECAY_ZERO_SKIP_EN to skip decay and write-back for
// neurons whose potential is zero or denormal.
//
// Ports:
//   CLK, RESET                  clock (rising edge), asynchronous active-high reset
//   timestep_start              one-cycle pulse that begins a sweep
//   neuron_count                neurons to sweep, sampled on an accepted start
//   adder_busy                  potential adder owns the memory this cycle
//   mem_rd_en / mem_wr_en       memory strobes (suppressed while adder_busy)
//   mem_addr                    read/write address
//   mem_wr_data                 write-back data
//   mem_rd_data / mem_rd_rate   read data, valid the cycle after mem_rd_en
//   decay_start                 one-cycle request to the decay unit
//   decay_potential             operand to the decay unit
//   decay_rate                  rate to the decay unit
//   decay_done / decay_result   decay unit response
//   busy                        sweep in progress
//   sweep_done                  one-cycle end-of-sweep pulse
//   overrun                     sticky: start arrived while not idle
module decay_sweep_controller #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 32,
    parameter int RATE_W = 4
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              timestep_start,
    input  logic [ADDR_W-1:0] neuron_count,
    input  logic              adder_busy,
    output logic              mem_rd_en,
    output logic              mem_wr_en,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wr_data,
    input  logic [DATA_W-1:0] mem_rd_data,
    input  logic [RATE_W-1:0] mem_rd_rate,
    output logic              decay_start,
    output logic [DATA_W-1:0] decay_potential,
    output logic [RATE_W-1:0] decay_rate,
    input  logic              decay_done,
    input  logic [DATA_W-1:0] decay_result,
    output logic              busy,
    output logic              sweep_done,
    output logic              overrun
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RD    = 3'd1,
        CAP   = 3'd2,
        ISSUE = 3'd3,
        WAITD = 3'd4,
        WR    = 3'd5,
        DONE  = 3'd6
    } state_t;

    localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

    state_t            state;
    logic [ADDR_W-1:0] cnt;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] pot_q;
    logic [RATE_W-1:0] rate_q;
    logic [DATA_W-1:0] res_q;
    logic              overrun_q;
    logic              last_addr;

    // cnt is never zero outside IDLE/DONE, so cnt-1 cannot underflow here
    assign last_addr = (addr == (cnt - ADDR_ONE));

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state     <= IDLE;
            cnt       <= '0;
            addr      <= '0;
            pot_q     <= '0;
            rate_q    <= '0;
            res_q     <= '0;
            overrun_q <= 1'b0;
        end else begin
            if (timestep_start && (state != IDLE)) begin
                overrun_q <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (timestep_start) begin
                        cnt   <= neuron_count;
                        addr  <= '0;
                        state <= (neuron_count == '0) ? DONE : RD;
                    end
                end
                RD: begin
                    if (!adder_busy) begin
                        state <= CAP;
                    end
                end
                CAP: begin
                    pot_q  <= mem_rd_data;
                    rate_q <= mem_rd_rate;
`ifdef DECAY_ZERO_SKIP_EN
                    // zero/denormal exponent: nothing to decay, move straight on
                    if (mem_rd_data[30:23] == 8'd0) begin
                        if (last_addr) begin
                            state <= DONE;
                        end else begin
                            addr  <= addr + ADDR_ONE;
                            state <= RD;
                        end
                    end else begin
                        state <= ISSUE;
                    end
`else
                    state <= ISSUE;
`endif
                end
                ISSUE: begin
                    state <= WAITD;
                end
                WAITD: begin
                    if (decay_done) begin
                        res_q <= decay_result;
                        state <= WR;
                    end
                end
                WR: begin
                    if (!adder_busy) begin
                        if (last_addr) begin
                            state <= DONE;
                        end else begin
                            addr  <= addr + ADDR_ONE;
                            state <= RD;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Strobes yield to the adder combinationally; everything else decodes from registers
    assign mem_rd_en       = (state == RD) && !adder_busy;
    assign mem_wr_en       = (state == WR) && !adder_busy;
    assign mem_addr        = addr;
    assign mem_wr_data     = res_q;
    assign decay_start     = (state == ISSUE);
    assign decay_potential = pot_q;
    assign decay_rate      = rate_q;
    assign busy            = (state != IDLE) && (state != DONE);
    assign sweep_done      = (state == DONE);
    assign overrun         = overrun_q;

endmodule

// File: tb/tb_decay_sweep_controller.sv
// tb/tb_decay_sweep_controller.sv - directed table-driven bench for decay_sweep_controller
module tb_decay_sweep_controller;

    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic        timestep_start = 1'b0;
    logic [11:0] neuron_count = 12'd0;
    logic        adder_busy = 1'b0;
    logic        mem_rd_en, mem_wr_en;
    logic [11:0] mem_addr;
    logic [31:0] mem_wr_data;
    logic [31:0] mem_rd_data = 32'd0;
    logic [3:0]  mem_rd_rate = 4'd0;
    logic        decay_start;
    logic [31:0] decay_potential;
    logic [3:0]  decay_rate;
    logic        decay_done = 1'b0;
    logic [31:0] decay_result = 32'd0;
    logic        busy, sweep_done, overrun;

    decay_sweep_controller dut (
        .CLK(CLK), .RESET(RESET), .timestep_start(timestep_start), .neuron_count(neuron_count),
        .adder_busy(adder_busy), .mem_rd_en(mem_rd_en), .mem_wr_en(mem_wr_en), .mem_addr(mem_addr),
        .mem_wr_data(mem_wr_data), .mem_rd_data(mem_rd_data), .mem_rd_rate(mem_rd_rate),
        .decay_start(decay_start), .decay_potential(decay_potential), .decay_rate(decay_rate),
        .decay_done(decay_done), .decay_result(decay_result), .busy(busy),
        .sweep_done(sweep_done), .overrun(overrun)
    );

    always #5 CLK = ~CLK;

    int tests = 0;
    int fails = 0;

    logic [31:0] mem_pot [16];
    logic [3:0]  mem_rate [16];
    int          dly = 1;
    bit          spur_en = 1'b0;
    logic [63:0] stall_mask = 64'd0;

    logic [11:0] wr_addr_q [$];
    logic [31:0] wr_data_q [$];
    int n_starts = 0, n_done = 0, strobe_viol = 0, iss_viol = 0, busy_viol = 0;

    logic        seen_rd = 1'b0, seen_start = 1'b0;
    logic [11:0] seen_addr = 12'd0, last_rd_addr = 12'd0;
    logic [31:0] seen_pot = 32'd0, res_hold = 32'd0;
    int          cd = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Observe DUT outputs mid-cycle
    always @(negedge CLK) begin
        seen_rd    = mem_rd_en;
        seen_addr  = mem_addr;
        seen_start = decay_start;
        seen_pot   = decay_potential;
        if ((mem_rd_en || mem_wr_en) && adder_busy) strobe_viol++;
        if (mem_wr_en) begin
            wr_addr_q.push_back(mem_addr);
            wr_data_q.push_back(mem_wr_data);
        end
        if (decay_start) begin
            n_starts++;
            if (decay_potential !== mem_pot[last_rd_addr[3:0]] ||
                decay_rate !== mem_rate[last_rd_addr[3:0]]) iss_viol++;
        end
        if (mem_rd_en) last_rd_addr = mem_addr;
        if (sweep_done) n_done++;
    end

    // Memory and decay-unit models, driven just after the rising edge
    always @(posedge CLK) begin
        #1;
        if (seen_rd) begin
            mem_rd_data = mem_pot[seen_addr[3:0]];
            mem_rd_rate = mem_rate[seen_addr[3:0]];
        end
        if (cd > 0) cd--;
        if (seen_start) begin
            cd       = dly;
            res_hold = seen_pot - 32'h0080_0000;
        end
        if (cd == 1) begin
            decay_done   = 1'b1;
            decay_result = res_hold;
        end else if (spur_en && seen_rd) begin
            decay_done   = 1'b1;
            decay_result = 32'hDEAD_BEEF;
        end else begin
            decay_done   = 1'b0;
            decay_result = 32'h0;
        end
    end

    task automatic fill_mem(input bit varied);
        for (int i = 0; i < 16; i++) begin
            mem_pot[i]  = varied ? (32'h4100_0000 + (i << 12)) : 32'h4100_0000;
            mem_rate[i] = varied ? 4'(i + 1) : 4'b0010;
        end
    endtask

    task automatic clear_logs();
        wr_addr_q.delete();
        wr_data_q.delete();
        n_starts = 0; n_done = 0; strobe_viol = 0; iss_viol = 0; busy_viol = 0;
    endtask

    // Start a sweep; lat = cycles from the start cycle to the sweep_done cycle
    task automatic run_sweep(input logic [11:0] n, input int ovr_cyc, output int lat);
        bit done_seen;
        clear_logs();
        @(posedge CLK); #1;
        timestep_start = 1'b1;
        neuron_count   = n;
        adder_busy     = stall_mask[0];
        lat = 0;
        done_seen = 1'b0;
        while (lat < 200 && !done_seen) begin
            @(posedge CLK); #1;
            lat++;
            timestep_start = (lat == ovr_cyc);
            neuron_count   = 12'hFFF ^ 12'(lat);
            adder_busy     = (lat < 64) ? stall_mask[lat] : 1'b0;
            @(negedge CLK);
            if (sweep_done) done_seen = 1'b1;
            else if (!busy) busy_viol++;
        end
        @(posedge CLK); #1;
        timestep_start = 1'b0;
        adder_busy     = 1'b0;
    endtask

    typedef struct {
        logic [11:0] n;
        int          dly;
        bit          spur;
        logic [63:0] stall;
        bit          varied;
        int          ovr;
        int          exp_lat;
        logic        exp_ovr;
    } vec_t;

    vec_t vecs [7];

    initial begin
        int lat, nw;
        logic [31:0] idle_viol;

        vecs[0] = '{12'd4, 1, 1'b0, 64'd0, 1'b0, 0, 21, 1'b0};
        vecs[1] = '{12'd4, 1, 1'b0, 64'h0000_0000_000C_01C0, 1'b0, 0, 26, 1'b0};
        vecs[2] = '{12'd3, 7, 1'b1, 64'd0, 1'b1, 0, 34, 1'b0};
        vecs[3] = '{12'd0, 1, 1'b0, 64'd0, 1'b1, 0, 1, 1'b0};
        vecs[4] = '{12'd1, 1, 1'b0, 64'd0, 1'b1, 0, 6, 1'b0};
        vecs[5] = '{12'd5, 2, 1'b0, 64'd0, 1'b1, 0, 31, 1'b0};
        vecs[6] = '{12'd4, 1, 1'b0, 64'd0, 1'b1, 5, 21, 1'b1};

        fill_mem(1'b0);

        // Reset, then idle quietly for 20 cycles
        repeat (3) @(posedge CLK);
        #1 RESET = 1'b0;
        @(negedge CLK);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_overrun", {31'd0, overrun}, 32'd0);
        check("rst_mem_addr", {20'd0, mem_addr}, 32'd0);
        check("rst_wr_data", mem_wr_data, 32'd0);
        idle_viol = 0;
        repeat (20) begin
            @(negedge CLK);
            if (mem_rd_en || mem_wr_en || decay_start || busy || sweep_done || overrun ||
                decay_potential != 0 || decay_rate != 0) idle_viol++;
        end
        check("idle_quiet", idle_viol, 32'd0);

        for (int v = 0; v < 7; v++) begin
            fill_mem(vecs[v].varied);
            dly        = vecs[v].dly;
            spur_en    = vecs[v].spur;
            stall_mask = vecs[v].stall;
            run_sweep(vecs[v].n, vecs[v].ovr, lat);
            repeat (3) @(negedge CLK);
            check($sformatf("v%0d_latency", v), lat, vecs[v].exp_lat);
            check($sformatf("v%0d_writes", v), wr_addr_q.size(), 32'(vecs[v].n));
            check($sformatf("v%0d_starts", v), n_starts, 32'(vecs[v].n));
            check($sformatf("v%0d_strobe_while_adder", v), strobe_viol, 0);
            check($sformatf("v%0d_issue_operands", v), iss_viol, 0);
            check($sformatf("v%0d_busy_gap", v), busy_viol, 0);
            check($sformatf("v%0d_overrun", v), {31'd0, overrun}, {31'd0, vecs[v].exp_ovr});
            nw = (wr_addr_q.size() < int'(vecs[v].n)) ? wr_addr_q.size() : int'(vecs[v].n);
            for (int i = 0; i < nw; i++) begin
                check($sformatf("v%0d_wr%0d_addr", v, i), {20'd0, wr_addr_q[i]}, 32'(i));
                check($sformatf("v%0d_wr%0d_data", v, i), wr_data_q[i], mem_pot[i] - 32'h0080_0000);
            end
            spur_en    = 1'b0;
            stall_mask = 64'd0;
        end

        // Reset while waiting on a slow decay unit: no write afterwards
        fill_mem(1'b0);
        dly = 7;
        clear_logs();
        @(posedge CLK); #1;
        timestep_start = 1'b1;
        neuron_count   = 12'd2;
        repeat (4) begin
            @(posedge CLK); #1;
            timestep_start = 1'b0;
        end
        RESET = 1'b1;
        repeat (2) @(posedge CLK);
        #1 RESET = 1'b0;
        clear_logs();
        repeat (15) @(negedge CLK);
        check("rstmid_writes", wr_addr_q.size(), 0);
        check("rstmid_starts", n_starts, 0);
        check("rstmid_sweep_done", n_done, 0);
        check("rstmid_busy", {31'd0, busy}, 32'd0);
        check("rstmid_overrun", {31'd0, overrun}, 32'd0);
        check("rstmid_mem_addr", {20'd0, mem_addr}, 32'd0);

        // Start landing in the DONE cycle is overrun, not a new sweep
        dly = 1;
        run_sweep(12'd1, 6, lat);
        repeat (5) @(negedge CLK);
        check("done_ovr_latency", lat, 6);
        check("done_ovr_overrun", {31'd0, overrun}, 32'd1);
        check("done_ovr_busy", {31'd0, busy}, 32'd0);
        check("done_ovr_writes", wr_addr_q.size(), 1);

        // Zero potential at address 1
        RESET = 1'b1;
        @(posedge CLK); #1 RESET = 1'b0;
        fill_mem(1'b0);
        mem_pot[1] = 32'h0000_0000;
        run_sweep(12'd4, 0, lat);
        repeat (3) @(negedge CLK);
`ifdef DECAY_ZERO_SKIP_EN
        check("zero_latency", lat, 18);
        check("zero_writes", wr_addr_q.size(), 3);
        check("zero_starts", n_starts, 3);
        if (wr_addr_q.size() == 3) begin
            check("zero_wr1_addr", {20'd0, wr_addr_q[1]}, 32'd2);
            check("zero_wr1_data", wr_data_q[1], 32'h4080_0000);
        end
`else
        check("zero_latency", lat, 21);
        check("zero_writes", wr_addr_q.size(), 4);
        check("zero_starts", n_starts, 4);
        if (wr_addr_q.size() == 4) begin
            check("zero_wr1_addr", {20'd0, wr_addr_q[1]}, 32'd1);
            check("zero_wr1_data", wr_data_q[1], 32'hFF80_0000);
        end
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
